// File: rtl/ui_set_controller.sv
// ui_set_controller: button-driven editor for the time, alarm and countdown-timer settings.
// A confirm emits a one-cycle commit strobe with the edited value presented on out_*.
module ui_set_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_field,
    input  logic       btn_inc,
    input  logic       btn_confirm,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       set_time,
    output logic       set_alarm,
    output logic       set_timer,
    output logic [7:0] out_hour,
    output logic [7:0] out_min,
    output logic [7:0] out_sec,
    output logic [1:0] ui_mode,
    output logic [1:0] ui_field,
    output logic       editing
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ModeIdle  = 2'd0;
    localparam logic [1:0] ModeTime  = 2'd1;
    localparam logic [1:0] ModeAlarm = 2'd2;
    localparam logic [1:0] ModeTimer = 2'd3;

    localparam logic [7:0] HourMax     = 8'd23;
    localparam logic [7:0] MinSecMax   = 8'd59;
    localparam logic [7:0] TimerMinMax = 8'd10;

    typedef enum logic [2:0] {
        StIdle,
        StEditTime,
        StEditAlarm,
        StEditTimer,
        StCommit
    } state_e;

    state_e          r_state;
    logic [7:0]      r_hour, r_min, r_sec;
    logic [7:0]      r_alarm_hour, r_alarm_min, r_alarm_sec;
    logic [1:0]      r_field;
    logic [1:0]      r_mode;
    logic            r_editing;
    logic            r_set_time, r_set_alarm, r_set_timer;
    logic [CntW-1:0] r_cnt;

    logic            w_is_timer;
    logic [1:0]      w_field_next;
    logic [7:0]      w_hour_inc, w_min_inc, w_sec_inc;

    function automatic logic [7:0] wrap_inc(input logic [7:0] val, input logic [7:0] lim);
        return (val >= lim) ? 8'd0 : val + 8'd1;
    endfunction

    // Timer edits only min/sec, so hour stays at its 0 preload for the whole session.
    always_comb begin
        w_is_timer   = (r_state == StEditTimer);
        w_field_next = (r_field >= (w_is_timer ? 2'd1 : 2'd2)) ? 2'd0 : r_field + 2'd1;
        w_hour_inc   = r_hour;
        w_min_inc    = r_min;
        w_sec_inc    = r_sec;
        if (w_is_timer) begin
            case (r_field)
                2'd0:    w_min_inc = wrap_inc(r_min, TimerMinMax);
                2'd1:    w_sec_inc = wrap_inc(r_sec, MinSecMax);
                default: ;
            endcase
        end else begin
            case (r_field)
                2'd0:    w_hour_inc = wrap_inc(r_hour, HourMax);
                2'd1:    w_min_inc  = wrap_inc(r_min, MinSecMax);
                2'd2:    w_sec_inc  = wrap_inc(r_sec, MinSecMax);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_hour       <= 8'd0;
            r_min        <= 8'd0;
            r_sec        <= 8'd0;
            r_alarm_hour <= 8'd0;
            r_alarm_min  <= 8'd0;
            r_alarm_sec  <= 8'd0;
            r_field      <= 2'd0;
            r_mode       <= ModeIdle;
            r_editing    <= 1'b0;
            r_set_time   <= 1'b0;
            r_set_alarm  <= 1'b0;
            r_set_timer  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_set_time  <= 1'b0;
            r_set_alarm <= 1'b0;
            r_set_timer <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (btn_mode) begin
                        r_state   <= StEditTime;
                        r_mode    <= ModeTime;
                        r_editing <= 1'b1;
                        r_field   <= 2'd0;
                        r_hour    <= cur_hour;
                        r_min     <= cur_min;
                        r_sec     <= cur_sec;
                    end
                end

                StEditTime, StEditAlarm, StEditTimer: begin
                    if (btn_confirm) begin
                        r_state     <= StCommit;
                        r_editing   <= 1'b0;
                        r_cnt       <= '0;
                        r_set_time  <= (r_state == StEditTime);
                        r_set_alarm <= (r_state == StEditAlarm);
                        r_set_timer <= (r_state == StEditTimer);
                        if (r_state == StEditAlarm) begin
                            r_alarm_hour <= r_hour;
                            r_alarm_min  <= r_min;
                            r_alarm_sec  <= r_sec;
                        end
                    end else if (btn_mode) begin
                        // Advancing the mode drops the pending edit without a strobe.
                        r_field <= 2'd0;
                        r_cnt   <= '0;
                        case (r_state)
                            StEditTime: begin
                                r_state <= StEditAlarm;
                                r_mode  <= ModeAlarm;
                                r_hour  <= r_alarm_hour;
                                r_min   <= r_alarm_min;
                                r_sec   <= r_alarm_sec;
                            end
                            StEditAlarm: begin
                                r_state <= StEditTimer;
                                r_mode  <= ModeTimer;
                                r_hour  <= 8'd0;
                                r_min   <= 8'd0;
                                r_sec   <= 8'd0;
                            end
                            default: begin
                                r_state   <= StIdle;
                                r_mode    <= ModeIdle;
                                r_editing <= 1'b0;
                            end
                        endcase
                    end else if (btn_field) begin
                        r_field <= w_field_next;
                        r_cnt   <= '0;
                    end else if (btn_inc) begin
                        r_hour <= w_hour_inc;
                        r_min  <= w_min_inc;
                        r_sec  <= w_sec_inc;
                        r_cnt  <= '0;
                    end else if (r_cnt == CntLast) begin
                        r_state   <= StIdle;
                        r_mode    <= ModeIdle;
                        r_editing <= 1'b0;
                        r_field   <= 2'd0;
                        r_cnt     <= '0;
                    end else if (r_cnt < CntLast) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                StCommit: begin
                    r_state <= StIdle;
                    r_mode  <= ModeIdle;
                    r_field <= 2'd0;
                    r_cnt   <= '0;
                end

                default: begin
                    r_state   <= StIdle;
                    r_mode    <= ModeIdle;
                    r_editing <= 1'b0;
                    r_field   <= 2'd0;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

    assign set_time  = r_set_time;
    assign set_alarm = r_set_alarm;
    assign set_timer = r_set_timer;
    assign out_hour  = r_hour;
    assign out_min   = r_min;
    assign out_sec   = r_sec;
    assign ui_mode   = r_mode;
    assign ui_field  = r_field;
    assign editing   = r_editing;

endmodule

// File: tb/tb_ui_set_controller.sv
// Directed bench for ui_set_controller: stimulus pushes expected commits into a queue and
// a negedge monitor pops and compares whenever a strobe appears.
module tb_ui_set_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       btn_mode = 1'b0, btn_field = 1'b0, btn_inc = 1'b0, btn_confirm = 1'b0;
    logic [7:0] cur_hour = 8'd0, cur_min = 8'd0, cur_sec = 8'd0;
    logic       set_time, set_alarm, set_timer;
    logic [7:0] out_hour, out_min, out_sec;
    logic [1:0] ui_mode, ui_field;
    logic       editing;

    always #5 clk = ~clk;

    ui_set_controller #(.TIMEOUT_CYCLES(30)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_mode   (btn_mode),
        .btn_field  (btn_field),
        .btn_inc    (btn_inc),
        .btn_confirm(btn_confirm),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .set_time   (set_time),
        .set_alarm  (set_alarm),
        .set_timer  (set_timer),
        .out_hour   (out_hour),
        .out_min    (out_min),
        .out_sec    (out_sec),
        .ui_mode    (ui_mode),
        .ui_field   (ui_field),
        .editing    (editing)
    );

    localparam logic [2:0] StbTime  = 3'b100;
    localparam logic [2:0] StbAlarm = 3'b010;
    localparam logic [2:0] StbTimer = 3'b001;

    typedef struct packed {
        logic [2:0] strb;
        logic [7:0] hr;
        logic [7:0] mn;
        logic [7:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (set_time | set_alarm | set_timer) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", {29'd0, set_time, set_alarm, set_timer}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("strobe_kind", {29'd0, set_time, set_alarm, set_timer}, {29'd0, e.strb});
                chk("out_hour", {24'd0, out_hour}, {24'd0, e.hr});
                chk("out_min", {24'd0, out_min}, {24'd0, e.mn});
                chk("out_sec", {24'd0, out_sec}, {24'd0, e.sc});
            end
        end
    end

    task automatic pulse(input logic m, input logic f, input logic i, input logic c);
        btn_mode = m; btn_field = f; btn_inc = i; btn_confirm = c;
        @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_field = 1'b0; btn_inc = 1'b0; btn_confirm = 1'b0;
    endtask

    task automatic press(input int n, input logic m, input logic f, input logic i);
        repeat (n) pulse(m, f, i, 1'b0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_commit(input logic [2:0] s, input logic [7:0] h,
                                 input logic [7:0] m, input logic [7:0] sec);
        exp_t e;
        e.strb = s; e.hr = h; e.mn = m; e.sc = sec;
        q.push_back(e);
    endtask

    task automatic confirm_and_idle();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_cycles(1);
    endtask

    task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        cur_hour = h; cur_min = m; cur_sec = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        chk("rst_editing", {31'd0, editing}, 32'd0);
        chk("rst_ui_mode", {30'd0, ui_mode}, 32'd0);
        chk("rst_ui_field", {30'd0, ui_field}, 32'd0);
        chk("rst_strobes", {29'd0, set_time, set_alarm, set_timer}, 32'd0);
        chk("rst_out", {8'd0, out_hour, out_min, out_sec}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(1);
        chk("idle_after_release", {30'd0, ui_mode}, 32'd0);

        // field/inc/confirm ignored in IDLE
        pulse(1'b0, 1'b1, 1'b1, 1'b1);
        chk("idle_ignores_editing", {31'd0, editing}, 32'd0);
        chk("idle_ignores_mode", {30'd0, ui_mode}, 32'd0);

        // Time edit: 13:45:07, min +15 wraps to 0
        set_cur(8'd13, 8'd45, 8'd7);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("time_ui_mode", {30'd0, ui_mode}, 32'd1);
        chk("time_editing", {31'd0, editing}, 32'd1);
        chk("time_field0", {30'd0, ui_field}, 32'd0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("time_field1", {30'd0, ui_field}, 32'd1);
        press(15, 1'b0, 1'b0, 1'b1);
        expect_commit(StbTime, 8'd13, 8'd0, 8'd7);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("commit_ui_mode", {30'd0, ui_mode}, 32'd1);
        chk("commit_editing", {31'd0, editing}, 32'd0);
        wait_cycles(1);
        chk("after_commit_mode", {30'd0, ui_mode}, 32'd0);

        // Field wraps 2->0, then hour increments
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        press(3, 1'b0, 1'b1, 1'b0);
        chk("time_field_wrap", {30'd0, ui_field}, 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_commit(StbTime, 8'd14, 8'd45, 8'd7);
        confirm_and_idle();

        // 23:59:59 each field wraps to 0
        set_cur(8'd23, 8'd59, 8'd59);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_commit(StbTime, 8'd0, 8'd0, 8'd0);
        confirm_and_idle();

        // Alarm: hour +24 wraps to 0, then reload committed value
        set_cur(8'd13, 8'd45, 8'd7);
        press(2, 1'b1, 1'b0, 1'b0);
        chk("alarm_ui_mode", {30'd0, ui_mode}, 32'd2);
        press(24, 1'b0, 1'b0, 1'b1);
        expect_commit(StbAlarm, 8'd0, 8'd0, 8'd0);
        confirm_and_idle();
        press(2, 1'b1, 1'b0, 1'b0);
        expect_commit(StbAlarm, 8'd0, 8'd0, 8'd0);
        confirm_and_idle();
        press(2, 1'b1, 1'b0, 1'b0);
        press(7, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        press(2, 1'b0, 1'b0, 1'b1);
        expect_commit(StbAlarm, 8'd7, 8'd2, 8'd0);
        confirm_and_idle();
        // TIME edit discarded by mode; ALARM preloads 07:02:00
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_commit(StbAlarm, 8'd8, 8'd2, 8'd0);
        confirm_and_idle();

        // Timer: min +11 wraps 10->0, sec +5
        press(3, 1'b1, 1'b0, 1'b0);
        chk("timer_ui_mode", {30'd0, ui_mode}, 32'd3);
        press(11, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("timer_field1", {30'd0, ui_field}, 32'd1);
        press(5, 1'b0, 1'b0, 1'b1);
        expect_commit(StbTimer, 8'd0, 8'd0, 8'd5);
        confirm_and_idle();
        press(3, 1'b1, 1'b0, 1'b0);
        press(3, 1'b0, 1'b0, 1'b1);
        press(2, 1'b0, 1'b1, 1'b0);
        chk("timer_field_wrap", {30'd0, ui_field}, 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_commit(StbTimer, 8'd0, 8'd4, 8'd0);
        confirm_and_idle();
        press(4, 1'b1, 1'b0, 1'b0);
        chk("mode_cycle_idle", {30'd0, ui_mode}, 32'd0);
        chk("mode_cycle_editing", {31'd0, editing}, 32'd0);

        // Priority: confirm over mode, field over inc, mode over inc
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_commit(StbTime, 8'd13, 8'd45, 8'd7);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        chk("prio_commit_mode", {30'd0, ui_mode}, 32'd1);
        wait_cycles(1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        chk("prio_field_over_inc", {30'd0, ui_field}, 32'd1);
        expect_commit(StbTime, 8'd13, 8'd45, 8'd7);
        confirm_and_idle();
        press(2, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk("prio_mode_over_inc", {30'd0, ui_mode}, 32'd3);
        expect_commit(StbTimer, 8'd0, 8'd0, 8'd0);
        confirm_and_idle();

        // Inactivity timeout after 30 idle cycles
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(29);
        chk("timeout_not_yet", {31'd0, editing}, 32'd1);
        wait_cycles(1);
        chk("timeout_editing", {31'd0, editing}, 32'd0);
        chk("timeout_mode", {30'd0, ui_mode}, 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cycles(20);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_cycles(29);
        chk("timeout_restart", {31'd0, editing}, 32'd1);
        wait_cycles(1);
        chk("timeout_after_btn", {31'd0, editing}, 32'd0);

        // Reset during COMMIT suppresses the strobe
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rstc_strobes", {29'd0, set_time, set_alarm, set_timer}, 32'd0);
        chk("rstc_out", {8'd0, out_hour, out_min, out_sec}, 32'd0);
        chk("rstc_ui", {28'd0, ui_mode, ui_field}, 32'd0);
        chk("rstc_editing", {31'd0, editing}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(1);
        chk("rstc_idle", {31'd0, editing, ui_mode}, 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rstc_first_edit", {30'd0, ui_mode}, 32'd1);
        // Stored alarm was cleared by reset
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_commit(StbAlarm, 8'd0, 8'd0, 8'd0);
        confirm_and_idle();

        wait_cycles(3);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
